// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multiport register file: a per-byte-lane view
// of a write port and the priority merge used by both storage and read bypass.
package regfile_pkg;

    localparam int LANE_W = 8;

    // One byte lane of a write port; index is widened so helpers stay width-agnostic.
    typedef struct packed {
        logic              en;
        logic [31:0]       index;
        logic [LANE_W-1:0] data;
        logic              be;
    } wr_lane_t;

    function automatic logic port_targets(input wr_lane_t w, input logic [31:0] idx);
        return w.en && (w.index == idx);
    endfunction

    function automatic logic lane_hit(input wr_lane_t w, input logic [31:0] idx);
        return port_targets(w, idx) && w.be;
    endfunction

    // Port 1 is applied last so it wins a same-lane collision.
    function automatic logic [LANE_W-1:0] merge_lane(
        input logic [LANE_W-1:0] old_val,
        input wr_lane_t          w0,
        input wr_lane_t          w1,
        input logic [31:0]       idx
    );
        logic [LANE_W-1:0] res;
        res = old_val;
        if (lane_hit(w0, idx)) res = w0.data;
        if (lane_hit(w1, idx)) res = w1.data;
        return res;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: scoreboard-aware ready, optional same-cycle write
// forwarding, and the rd_valid/rd_data output registers.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int NUM_REGS   = 8,
    parameter int DATA_WIDTH = 32,
    parameter int BYPASS     = 1,
    parameter int IDX_W      = 3,
    parameter int BE_W       = 4
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 rd_req,
    input  logic [IDX_W-1:0]                     rd_index,
    input  logic [NUM_REGS-1:0]                  pending,
    input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs,
    input  wr_lane_t [1:0][BE_W-1:0]             wr_lane,
    output logic                                 rd_ready,
    output logic                                 rd_valid,
    output logic [DATA_WIDTH-1:0]                rd_data
);

    logic                  in_range_s;
    logic                  sel_pend_s;
    logic                  wr_hit_s;
    logic                  rd_ready_s;
    logic [31:0]           idx_s;
    logic [DATA_WIDTH-1:0] sel_reg_s;
    logic [DATA_WIDTH-1:0] fwd_s;
    logic                  rd_valid_d, rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_d, rd_data_q;

    // Select the addressed register, compute ready and the next output values.
    always_comb begin
        idx_s      = 32'(rd_index);
        in_range_s = 1'b0;
        sel_pend_s = 1'b0;
        sel_reg_s  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            in_range_s = in_range_s | (rd_index == IDX_W'(i));
            sel_pend_s = sel_pend_s | ((rd_index == IDX_W'(i)) & pending[i]);
            sel_reg_s  = sel_reg_s  | ((rd_index == IDX_W'(i)) ? regs[i] : '0);
        end
        wr_hit_s = port_targets(wr_lane[0][0], idx_s) || port_targets(wr_lane[1][0], idx_s);
        for (int b = 0; b < BE_W; b++) begin
            fwd_s[8*b +: 8] = merge_lane(sel_reg_s[8*b +: 8], wr_lane[0][b], wr_lane[1][b], idx_s);
        end
        if (BYPASS != 0) begin
            rd_ready_s = !sel_pend_s || wr_hit_s;
        end else begin
            rd_ready_s = !sel_pend_s;
        end
        rd_valid_d = rd_req && rd_ready_s;
        // Out-of-range reads must not pick up forwarded data aimed at a phantom index.
        if (!rd_valid_d) begin
            rd_data_d = rd_data_q;
        end else if (!in_range_s) begin
            rd_data_d = '0;
        end else if (BYPASS != 0) begin
            rd_data_d = fwd_s;
        end else begin
            rd_data_d = sel_reg_s;
        end
    end

    // Output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_ready = rd_ready_s;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: rtl/multiport_register_file.sv
// Parametrised register file: two byte-enabled write ports, a pending-producer
// scoreboard and READ_PORTS registered read ports.
module multiport_register_file
    import regfile_pkg::*;
#(
    parameter  int NUM_REGS   = 8,
    parameter  int DATA_WIDTH = 32,
    parameter  int READ_PORTS = 2,
    parameter  int BYPASS     = 1,
    localparam int IDX_W      = $clog2(NUM_REGS),
    localparam int BE_W       = DATA_WIDTH / 8
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [1:0]                             wr_en,
    input  logic [1:0][IDX_W-1:0]                  wr_index,
    input  logic [1:0][DATA_WIDTH-1:0]             wr_data,
    input  logic [1:0][BE_W-1:0]                   wr_be,
    input  logic                                   rsv_en,
    input  logic [IDX_W-1:0]                       rsv_index,
    input  logic [READ_PORTS-1:0]                  rd_req,
    input  logic [READ_PORTS-1:0][IDX_W-1:0]       rd_index,
    output logic [READ_PORTS-1:0]                  rd_ready,
    output logic [READ_PORTS-1:0]                  rd_valid,
    output logic [READ_PORTS-1:0][DATA_WIDTH-1:0]  rd_data,
    output logic [NUM_REGS-1:0]                    pending,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]    regs_q
);

    wr_lane_t [1:0][BE_W-1:0]             wr_lane_s;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_d;
    logic [NUM_REGS-1:0]                  pending_d, pending_q;

    // Slice each write port into byte lanes for the shared merge helper.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < BE_W; b++) begin
                wr_lane_s[p][b].en    = wr_en[p];
                wr_lane_s[p][b].index = 32'(wr_index[p]);
                wr_lane_s[p][b].data  = wr_data[p][8*b +: 8];
                wr_lane_s[p][b].be    = wr_be[p][b];
            end
        end
    end

    // Next register and scoreboard state; only in-range indices are iterated, so
    // out-of-range writes and reserves fall through untouched.
    always_comb begin
        regs_d    = regs_q;
        pending_d = pending_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            for (int b = 0; b < BE_W; b++) begin
                regs_d[i][8*b +: 8] = merge_lane(regs_q[i][8*b +: 8], wr_lane_s[0][b],
                                                 wr_lane_s[1][b], 32'(i));
            end
            // A reserve in the same cycle as a write means a new producer: keep pending.
            if (rsv_en && (32'(rsv_index) == 32'(i))) begin
                pending_d[i] = 1'b1;
            end else if (port_targets(wr_lane_s[0][0], 32'(i)) ||
                         port_targets(wr_lane_s[1][0], 32'(i))) begin
                pending_d[i] = 1'b0;
            end else begin
                pending_d[i] = pending_q[i];
            end
        end
    end

    // Storage and scoreboard registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            regs_q    <= '0;
            pending_q <= '0;
        end else begin
            regs_q    <= regs_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

    for (genvar r = 0; r < READ_PORTS; r++) begin : g_rd
        regfile_read_port #(
            .NUM_REGS   (NUM_REGS),
            .DATA_WIDTH (DATA_WIDTH),
            .BYPASS     (BYPASS),
            .IDX_W      (IDX_W),
            .BE_W       (BE_W)
        ) u_port (
            .clock    (clock),
            .reset    (reset),
            .rd_req   (rd_req[r]),
            .rd_index (rd_index[r]),
            .pending  (pending_q),
            .regs     (regs_q),
            .wr_lane  (wr_lane_s),
            .rd_ready (rd_ready[r]),
            .rd_valid (rd_valid[r]),
            .rd_data  (rd_data[r])
        );
    end

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench: two instances share stimulus, A = default (8 regs, bypass),
// B = 6 regs without bypass, so both read modes and out-of-range indices are covered.
module tb_multiport_register_file;

    logic              clock = 1'b0;
    logic              reset;
    logic [1:0]        wr_en;
    logic [1:0][2:0]   wr_index;
    logic [1:0][31:0]  wr_data;
    logic [1:0][3:0]   wr_be;
    logic              rsv_en;
    logic [2:0]        rsv_index;
    logic [1:0]        rd_req;
    logic [1:0][2:0]   rd_index;

    logic [1:0]        a_rd_ready, a_rd_valid, b_rd_ready, b_rd_valid;
    logic [1:0][31:0]  a_rd_data, b_rd_data;
    logic [7:0]        a_pending;
    logic [5:0]        b_pending;
    logic [7:0][31:0]  a_regs_q;
    logic [5:0][31:0]  b_regs_q;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    multiport_register_file #(.NUM_REGS(8), .DATA_WIDTH(32), .READ_PORTS(2), .BYPASS(1)) u_a (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
        .wr_be(wr_be), .rsv_en(rsv_en), .rsv_index(rsv_index), .rd_req(rd_req),
        .rd_index(rd_index), .rd_ready(a_rd_ready), .rd_valid(a_rd_valid),
        .rd_data(a_rd_data), .pending(a_pending), .regs_q(a_regs_q)
    );

    multiport_register_file #(.NUM_REGS(6), .DATA_WIDTH(32), .READ_PORTS(2), .BYPASS(0)) u_b (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
        .wr_be(wr_be), .rsv_en(rsv_en), .rsv_index(rsv_index), .rd_req(rd_req),
        .rd_index(rd_index), .rd_ready(b_rd_ready), .rd_valid(b_rd_valid),
        .rd_data(b_rd_data), .pending(b_pending), .regs_q(b_regs_q)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wr_en     = 2'b00;
        wr_index  = '0;
        wr_data   = '0;
        wr_be     = '0;
        rsv_en    = 1'b0;
        rsv_index = 3'd0;
        rd_req    = 2'b00;
        rd_index  = '0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #3;
        check("reset_a_regs",    a_regs_q,   256'h0);
        check("reset_a_pending", a_pending,  256'h0);
        check("reset_a_valid",   a_rd_valid, 256'h0);
        check("reset_b_regs",    b_regs_q,   256'h0);
        #9;
        reset = 1'b0;
        tick();

        // Byte-lane write onto a reset register, then read it back.
        wr_en = 2'b01; wr_index[0] = 3'd3; wr_data[0] = 32'hAABBCCDD; wr_be[0] = 4'b0101;
        tick();
        idle();
        check("be_a_reg3", a_regs_q[3], 256'h00BB00DD);
        check("be_b_reg3", b_regs_q[3], 256'h00BB00DD);
        rd_req[0] = 1'b1; rd_index[0] = 3'd3;
        #1;
        check("be_a_ready", a_rd_ready[0], 256'h1);
        tick();
        idle();
        check("be_a_valid", a_rd_valid[0], 256'h1);
        check("be_a_data",  a_rd_data[0],  256'h00BB00DD);
        check("be_b_data",  b_rd_data[0],  256'h00BB00DD);
        tick();
        check("hold_a_valid", a_rd_valid[0], 256'h0);
        check("hold_a_data",  a_rd_data[0],  256'h00BB00DD);

        // Same-index collision: full lanes, then port 1 on the low half only.
        wr_en = 2'b11; wr_index[0] = 3'd2; wr_index[1] = 3'd2;
        wr_data[0] = 32'h11111111; wr_data[1] = 32'h22222222;
        wr_be[0] = 4'b1111; wr_be[1] = 4'b1111;
        tick();
        check("coll_full", a_regs_q[2], 256'h22222222);
        wr_be[1] = 4'b0011;
        tick();
        idle();
        check("coll_half_a", a_regs_q[2], 256'h11112222);
        check("coll_half_b", b_regs_q[2], 256'h11112222);

        // Scoreboard stall on read port 1, released by a port-0 write.
        rsv_en = 1'b1; rsv_index = 3'd5;
        tick();
        idle();
        check("rsv_a_pend5", a_pending[5], 256'h1);
        check("rsv_b_pend5", b_pending[5], 256'h1);
        rd_req[1] = 1'b1; rd_index[1] = 3'd5;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_a_ready", a_rd_ready[1], 256'h0);
            check("stall_b_ready", b_rd_ready[1], 256'h0);
            tick();
            check("stall_a_valid", a_rd_valid[1], 256'h0);
            check("stall_b_valid", b_rd_valid[1], 256'h0);
        end
        wr_en = 2'b01; wr_index[0] = 3'd5; wr_data[0] = 32'h12345678; wr_be[0] = 4'b1111;
        #1;
        check("release_a_ready", a_rd_ready[1], 256'h1);
        check("release_b_ready", b_rd_ready[1], 256'h0);
        tick();
        wr_en = 2'b00;
        #1;
        check("release_a_valid", a_rd_valid[1], 256'h1);
        check("release_a_data",  a_rd_data[1],  256'h12345678);
        check("release_a_pend5", a_pending[5],  256'h0);
        check("release_b_valid", b_rd_valid[1], 256'h0);
        check("late_b_ready",    b_rd_ready[1], 256'h1);
        tick();
        idle();
        check("late_b_valid", b_rd_valid[1], 256'h1);
        check("late_b_data",  b_rd_data[1],  256'h12345678);

        // Read and write the same free index: bypass sees new data, non-bypass the old.
        wr_en = 2'b01; wr_index[0] = 3'd4; wr_data[0] = 32'h0000BEEF; wr_be[0] = 4'b1111;
        rd_req[0] = 1'b1; rd_index[0] = 3'd4;
        tick();
        idle();
        check("byp_a_data",  a_rd_data[0],  256'h0000BEEF);
        check("byp_b_valid", b_rd_valid[0], 256'h1);
        check("byp_b_data",  b_rd_data[0],  256'h0);

        // Reserve and write together, then a zero-lane write that only clears pending.
        rsv_en = 1'b1; rsv_index = 3'd1;
        wr_en = 2'b01; wr_index[0] = 3'd1; wr_data[0] = 32'hCAFEF00D; wr_be[0] = 4'b1111;
        tick();
        idle();
        check("rsvwr_reg1",  a_regs_q[1],  256'hCAFEF00D);
        check("rsvwr_pend1", a_pending[1], 256'h1);
        wr_en = 2'b10; wr_index[1] = 3'd1; wr_data[1] = 32'hFFFFFFFF; wr_be[1] = 4'b0000;
        tick();
        idle();
        check("be0_pend1", a_pending[1], 256'h0);
        check("be0_reg1",  a_regs_q[1],  256'hCAFEF00D);

        // Out-of-range for B (6 regs): write idx 7, reserve idx 6, read idx 6.
        wr_en = 2'b01; wr_index[0] = 3'd7; wr_data[0] = 32'hDEADBEEF; wr_be[0] = 4'b1111;
        rsv_en = 1'b1; rsv_index = 3'd6;
        tick();
        idle();
        check("oor_b_regs", b_regs_q,
              {64'h0, 32'h12345678, 32'h0000BEEF, 32'h00BB00DD, 32'h11112222, 32'hCAFEF00D, 32'h0});
        check("oor_b_pend", b_pending, 256'h0);
        check("oor_a_reg7", a_regs_q[7], 256'hDEADBEEF);
        check("oor_a_pend", a_pending,   256'h40);
        rd_req[0] = 1'b1; rd_index[0] = 3'd6;
        #1;
        check("oor_b_ready", b_rd_ready[0], 256'h1);
        check("oor_a_ready", a_rd_ready[0], 256'h0);
        tick();
        idle();
        check("oor_b_valid", b_rd_valid[0], 256'h1);
        check("oor_b_data",  b_rd_data[0],  256'h0);
        check("oor_a_valid", a_rd_valid[0], 256'h0);

        // Fill the scoreboard, get a read in flight, then reset between edges.
        for (int i = 0; i < 8; i++) begin
            rsv_en = 1'b1; rsv_index = 3'(i);
            tick();
        end
        idle();
        rsv_en = 1'b1; rsv_index = 3'd0;
        wr_en = 2'b01; wr_index[0] = 3'd0; wr_data[0] = 32'h5A5A5A5A; wr_be[0] = 4'b1111;
        rd_req[0] = 1'b1; rd_index[0] = 3'd0;
        tick();
        idle();
        check("pre_a_valid", a_rd_valid[0], 256'h1);
        check("pre_a_data",  a_rd_data[0],  256'h5A5A5A5A);
        check("pre_a_pend",  a_pending,     256'hFF);
        check("pre_b_pend",  b_pending,     256'h3F);
        #1;
        reset = 1'b1;
        #1;
        check("rst_a_valid", a_rd_valid, 256'h0);
        check("rst_a_data",  a_rd_data,  256'h0);
        check("rst_a_pend",  a_pending,  256'h0);
        check("rst_a_regs",  a_regs_q,   256'h0);
        check("rst_b_pend",  b_pending,  256'h0);
        check("rst_b_regs",  b_regs_q,   256'h0);
        #1;
        reset = 1'b0;
        wr_en = 2'b01; wr_index[0] = 3'd2; wr_data[0] = 32'h77665544; wr_be[0] = 4'b1111;
        tick();
        idle();
        rd_req[0] = 1'b1; rd_index[0] = 3'd2;
        tick();
        idle();
        check("post_a_valid", a_rd_valid[0], 256'h1);
        check("post_a_data",  a_rd_data[0],  256'h77665544);
        check("post_b_data",  b_rd_data[0],  256'h77665544);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multiport_register_file.md
Name: multiport_register_file

Overview:
- Parametrised next-generation register file for the w80386dx core, generalising the fixed 8x32 single-write test/debug register bank.
- Configurable depth, width and port counts; two write ports with byte-lane enables; registered read ports with valid/ready handshake.
- Pending-producer scoreboard for in-flight results, with optional write-to-read bypass.
- Serves as a common building block for the GPR, debug and test register banks.

Parameters:
NUM_REGS, 8, number of registers (>=2; need not be a power of 2)
DATA_WIDTH, 32, register width in bits (multiple of 8)
READ_PORTS, 2, number of independent read ports
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see pre-write value
Derived: IDX_W = $clog2(NUM_REGS); BE_W = DATA_WIDTH/8

Ports:
clock  input  1  clock, rising edge
reset  input  1  reset, asynchronous, active-high
wr_en  input  [2]  write enable per write port (port 1 has higher priority)
wr_index  input  [2][IDX_W]  write target per port
wr_data  input  [2][DATA_WIDTH]  write data per port
wr_be  input  [2][BE_W]  byte-lane enables per port
rsv_en  input  1  mark a register as pending (producer in flight)
rsv_index  input  IDX_W  register to mark pending
rd_req  input  [READ_PORTS]  read request per port
rd_index  input  [READ_PORTS][IDX_W]  read address per port
rd_ready  output  [READ_PORTS]  combinational: request accepted this cycle
rd_valid  output  [READ_PORTS]  registered: rd_data is new this cycle
rd_data  output  [READ_PORTS][DATA_WIDTH]  registered read data
pending  output  NUM_REGS  scoreboard bit per register
regs_q  output  [NUM_REGS][DATA_WIDTH]  direct view of every register

Behaviour:
- Reset (async, any time including mid-read): all registers, pending, rd_valid and rd_data go to 0 immediately. The first accepted request after deassertion follows the normal 1-cycle latency.
- Write: at posedge, for each port with wr_en=1, the byte lanes with wr_be[b]=1 of reg[wr_index] take wr_data[b]. Lanes with be=0 are unchanged.
- Write collision, same index, same lane: port 1 wins. Different lanes of the same index: both applied.
- wr_en=1 with wr_be=0 writes no data but still clears pending.
- Scoreboard: rsv_en sets pending[rsv_index] at posedge. Any wr_en to an index clears its pending bit.
- Reserve and write to the same index in one cycle: the write data lands and pending ends set (the new producer wins).
- Out-of-range index (>= NUM_REGS):
  - writes and reserves are ignored;
  - reads are always ready and return 0.
- rd_ready[r]:
  - BYPASS=1: !pending[rd_index] || any wr_en targets rd_index this cycle.
  - BYPASS=0: !pending[rd_index] only.
  - rd_ready is purely combinational from the inputs and state.
- Read accept: rd_req && rd_ready at posedge gives rd_valid=1 the next cycle (latency 1). rd_data is then:
  - BYPASS=1: the register value with this cycle's writes merged per lane (port 1 priority).
  - BYPASS=0: the pre-write value.
- Read not accepted (no request, or request while not ready): rd_valid=0 next cycle and rd_data holds its last value. The requester must hold rd_req and rd_index until rd_ready.
- Read ports are independent; any ports may read the same index in the same cycle.
- regs_q reflects register state after each posedge (no bypass).

Decomposition:
- Package regfile_pkg:
  - byte-lane enable helpers;
  - a function merging data/be pairs with priority;
  - typedef of the write-port struct {en, index, data, be}.
- Sub-module regfile_read_port, instantiated READ_PORTS times with generate. It contains the ready logic, bypass merge, and the rd_valid/rd_data registers.
- Storage, write-merge and scoreboard stay in the top module.

Test Plan:
- Byte-lane write: port 0 writes idx 3, data 0xAABBCCDD, be 4'b0101, onto a reset register. Read idx 3 -> rd_valid next cycle, rd_data 0x00BB00DD.
- Write collision: port 0 writes idx 2 = 0x11111111 and port 1 writes idx 2 = 0x22222222 in one cycle, full be -> regs_q[2] = 0x22222222. Same test with port 1 be=4'b0011 -> 0x11112222.
- Scoreboard stall: rsv idx 5, then read idx 5 -> rd_ready=0 and rd_valid=0 for 3 cycles. Port 0 writes 0x12345678 to idx 5:
  - BYPASS=1: rd_ready=1 that cycle, rd_data 0x12345678 the next cycle, pending[5]=0.
  - BYPASS=0: rd_ready rises one cycle later.
- Reserve+write same cycle: rsv idx 1 and write idx 1 = 0xCAFEF00D -> regs_q[1] = 0xCAFEF00D, pending[1] = 1.
- Reset mid-operation: assert reset between clock edges while rd_valid=1 and pending=8'hFF -> rd_valid, rd_data, pending and all regs_q read 0 before the next edge.
- Out-of-range (NUM_REGS=6): write idx 7 -> no register changes. Read idx 6 -> rd_ready=1, rd_data 0.
